// File: rtl/wb_req_queue.sv
// wb_req_queue: in-order request FIFO issuing one request at a time to wishbone_master.
// Define WBQ_TIMEOUT_EN to abort an ISSUE that waits TIMEOUT cycles (rsp_err_o=1).
module wb_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [3:0]  req_we_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        m_valid_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_we_o,
    input  logic [31:0] m_data_i,
    input  logic        m_valid_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_req_queue: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_req_queue: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_nx;
    logic          push;
    logic          pop;
    logic          expire;

    // Ready comes from the registered count, so a full queue refuses even while popping.
    assign req_ready_o = (count < FULL);
    assign push        = req_valid_i & req_ready_o;

    assign head      = mem[rd_ptr];
    assign m_valid_o = (state == ISSUE);
    assign m_addr_o  = head.addr;
    assign m_data_o  = head.data;
    assign m_we_o    = head.we;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (m_valid_i || expire) begin
                    pop      = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{addr: req_addr_i, data: req_data_i, we: req_we_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WBQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    // Held at zero outside ISSUE, so every issue starts counting from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state != ISSUE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign expire = (state == ISSUE) && !m_valid_i &&
                    (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_err_o <= 1'b0;
        end else if (pop) begin
            rsp_err_o <= expire;
        end
    end
`else
    assign expire    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= pop;
            if (pop) begin
                rsp_data_o <= expire ? 32'h0 : m_data_i;
            end
        end
    end

endmodule
